mem_stage_lsu: RTL and testbench
================================

# mem_stage_lsu

Load/store unit for the MEM stage of the RISCVX five-stage pipeline. It turns the EX/MEM load/store controls into transactions on the data-memory request/response bus. It formats returned data into `mem_data_MEM` for the MEM/WB register and stalls the pipeline until each access completes. Misaligned or illegal accesses are flagged without touching the bus.

## Interface
Parameters:
- `ADDR_W`, 32: address width; `dmem_addr` is always word-aligned.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `memread_MEM`  in  1  current MEM instruction is a load.
- `memwrite_MEM`  in  1  current MEM instruction is a store; never asserted together with `memread_MEM`.
- `funct3_MEM`  in  3  RV32I width/sign code: 0 B, 1 H, 2 W, 4 BU, 5 HU.
- `addr_MEM`  in  ADDR_W  byte address (ALU result).
- `store_data_MEM`  in  32  rs2 value for stores.
- `mem_data_MEM`  out  32  formatted load result, registered.
- `stall_MEM`  out  1  hold IF..MEM stages this cycle.
- `fault_MEM`  out  1  misaligned or illegal access; combinational.
- `dmem_req`  out  1  bus request.
- `dmem_we`  out  1  1 = write.
- `dmem_addr`  out  ADDR_W  `{addr_MEM[ADDR_W-1:2],2'b00}`.
- `dmem_wdata`  out  32  lane-replicated store data.
- `dmem_be`  out  4  byte enables; 0 on reads.
- `dmem_gnt`  in  1  request accepted this cycle.
- `dmem_rvalid`  in  1  read data valid.
- `dmem_rdata`  in  32  read data word.

## Operation
- FSM states:
  - IDLE: no transaction in progress.
  - REQ: `dmem_req`=1, held until `dmem_gnt`.
  - WAIT_DATA: waiting for `dmem_rvalid`.
  - DONE: one cycle, stall released.
- `access` = (`memread_MEM` | `memwrite_MEM`) & !`fault_MEM`.
- Fault conditions (`fault_MEM`=1):
  - any `funct3_MEM` not in {0,1,2,4,5} for loads, or not in {0,1,2} for stores;
  - H/HU with `addr[0]`=1;
  - W with `addr[1:0]`≠0.
- A faulting access causes no stall and no bus activity, and leaves `mem_data_MEM` unchanged.
- IDLE → REQ when `access`.
- REQ → DONE on `dmem_gnt` & `dmem_we`.
- REQ → WAIT_DATA on `dmem_gnt` & !`dmem_we`.
- WAIT_DATA → DONE on `dmem_rvalid`, capturing formatted data into `mem_data_MEM`.
- DONE → IDLE unconditionally. The access is never re-issued from DONE.
- `stall_MEM` = (IDLE & `access`) | REQ | WAIT_DATA. It is 0 in DONE, so the pipeline advances on the DONE edge.
- Store lanes, with `off` = `addr[1:0]`:
  - SB: `be` = 4'b0001<<`off`, `wdata` = byte×4.
  - SH: `be` = 4'b0011<<`off`, `wdata` = half×2.
  - SW: `be` = 4'b1111.
- Load formatting:
  - B: select byte `off`, sign-extend; BU zero-extends.
  - H: select half `addr[1]`, sign-extend; HU zero-extends.
  - W: pass through.
- `dmem_we`, `dmem_addr`, `dmem_wdata` and `dmem_be` are valid only while `dmem_req`=1. The pipeline keeps the MEM inputs stable while `stall_MEM`=1.
- `dmem_rvalid` outside WAIT_DATA is ignored.

## Timing
- Reset values: state IDLE, `mem_data_MEM`=0, `dmem_req`=0. `stall_MEM` is 0 unless MEM inputs request a non-faulting access.
- Store with `gnt` in its first REQ cycle:
  - cycle 0 IDLE, stall=1;
  - cycle 1 REQ with gnt, stall=1;
  - cycle 2 DONE, stall=0.
  - Total: 3 cycles.
- Load with `gnt` in REQ and `rvalid` one cycle later:
  - cycle 0 IDLE, stall=1;
  - cycle 1 REQ;
  - cycle 2 WAIT_DATA with rvalid;
  - cycle 3 DONE with `mem_data_MEM` valid, stall=0.
  - Total: 4 cycles.
- `gnt` and `rvalid` may be delayed arbitrarily; the stall extends accordingly.
- A `dmem_rvalid` in the same cycle as `dmem_gnt` is not accepted; data is taken only in WAIT_DATA.
- Back-to-back accesses: the next instruction enters MEM at the DONE→IDLE edge and starts in IDLE on the following cycle.
- Reset mid-transaction: immediate return to IDLE with `dmem_req`=0. A late `rvalid` after reset is ignored.

## Test plan
- SW addr 0x100, data 0xDEADBEEF, gnt on the first REQ cycle: `be`=4'hF, `dmem_addr`=0x100, stall high for exactly 2 cycles, no write of `mem_data_MEM`.
- SB addr 0x103, data 0x000000A5: `be`=4'b1000, `wdata`=0xA5A5A5A5.
- LB addr 0x102 with `rdata`=0x11803344: `mem_data_MEM`=0xFFFFFF80. Repeat with LBU: `mem_data_MEM`=0x00000080. LHU at 0x102: 0x00001180.
- LW with `gnt` delayed 3 cycles and `rvalid` delayed 2 cycles: stall held through both waits, data captured on `rvalid`, DONE for exactly one cycle.
- LW at 0x101 and LH at 0x103: `fault_MEM`=1, stall=0, `dmem_req` never asserted.
- Reset asserted during WAIT_DATA, then `rvalid` pulsed: `dmem_req`=0, `mem_data_MEM`=0, state IDLE, response ignored.

Source files
------------

// File: rtl/mem_stage_lsu_if.sv
// Data-memory request/response bus between the MEM-stage LSU and the data memory.
interface mem_stage_lsu_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [31:0]       dmem_wdata;
  logic [3:0]        dmem_be;
  logic              dmem_gnt;
  logic              dmem_rvalid;
  logic [31:0]       dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues data-memory transactions, formats load
// data for MEM/WB and stalls the pipeline until each access completes.
module mem_stage_lsu #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memread_MEM,
  input  logic              memwrite_MEM,
  input  logic [2:0]        funct3_MEM,
  input  logic [ADDR_W-1:0] addr_MEM,
  input  logic [31:0]       store_data_MEM,
  output logic [31:0]       mem_data_MEM,
  output logic              stall_MEM,
  output logic              fault_MEM,
  mem_stage_lsu_if.master   bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA, DONE} state_t;

  state_t      state;
  logic [1:0]  off;
  logic        illegal;
  logic        misaligned;
  logic        access;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_fmt;

  assign off = addr_MEM[1:0];

  // Width/alignment legality; stores have no unsigned variants.
  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    case (funct3_MEM)
      3'd0: illegal = 1'b0;
      3'd1: misaligned = addr_MEM[0];
      3'd2: misaligned = |addr_MEM[1:0];
      3'd4: illegal = memwrite_MEM;
      3'd5: begin
        illegal    = memwrite_MEM;
        misaligned = addr_MEM[0];
      end
      default: illegal = 1'b1;
    endcase
  end

  assign fault_MEM = (memread_MEM | memwrite_MEM) & (illegal | misaligned);
  assign access    = (memread_MEM | memwrite_MEM) & ~fault_MEM;
  assign stall_MEM = ((state == IDLE) & access) | (state == REQ) | (state == WAIT_DATA);

  // Store lane steering: data replicated across lanes, enables select the target bytes.
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = store_data_MEM;
    case (funct3_MEM[1:0])
      2'd0: begin
        be_c    = 4'(4'b0001 << off);
        wdata_c = {4{store_data_MEM[7:0]}};
      end
      2'd1: begin
        be_c    = 4'(4'b0011 << off);
        wdata_c = {2{store_data_MEM[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = store_data_MEM;
      end
    endcase
  end

  // Load formatting from the returned word.
  always_comb begin
    lane_byte = 8'(bus.dmem_rdata >> {off, 3'b000});
    lane_half = addr_MEM[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
    case (funct3_MEM)
      3'd0:    load_fmt = {{24{lane_byte[7]}}, lane_byte};
      3'd4:    load_fmt = {24'h000000, lane_byte};
      3'd1:    load_fmt = {{16{lane_half[15]}}, lane_half};
      3'd5:    load_fmt = {16'h0000, lane_half};
      default: load_fmt = bus.dmem_rdata;
    endcase
  end

  // Transaction FSM; bus outputs are captured on entry to REQ and held until grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      mem_data_MEM   <= 32'h0;
      bus.dmem_req   <= 1'b0;
      bus.dmem_we    <= 1'b0;
      bus.dmem_addr  <= '0;
      bus.dmem_wdata <= 32'h0;
      bus.dmem_be    <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            state          <= REQ;
            bus.dmem_req   <= 1'b1;
            bus.dmem_we    <= memwrite_MEM;
            bus.dmem_addr  <= {addr_MEM[ADDR_W-1:2], 2'b00};
            bus.dmem_wdata <= wdata_c;
            bus.dmem_be    <= memwrite_MEM ? be_c : 4'h0;
          end
        end
        REQ: begin
          if (bus.dmem_gnt) begin
            bus.dmem_req <= 1'b0;
            state        <= bus.dmem_we ? DONE : WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (bus.dmem_rvalid) begin
            mem_data_MEM <= load_fmt;
            state        <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomized scoreboard bench for mem_stage_lsu against a byte-addressed memory model.
module tb_mem_stage_lsu;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        memread_MEM, memwrite_MEM;
  logic [2:0]  funct3_MEM;
  logic [31:0] addr_MEM, store_data_MEM;
  logic [31:0] mem_data_MEM;
  logic        stall_MEM, fault_MEM;

  mem_stage_lsu_if #(.ADDR_W(32)) bus ();

  mem_stage_lsu #(.ADDR_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .memread_MEM    (memread_MEM),
    .memwrite_MEM   (memwrite_MEM),
    .funct3_MEM     (funct3_MEM),
    .addr_MEM       (addr_MEM),
    .store_data_MEM (store_data_MEM),
    .mem_data_MEM   (mem_data_MEM),
    .stall_MEM      (stall_MEM),
    .fault_MEM      (fault_MEM),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  bus_t        exp_bus[$];
  logic [31:0] exp_load[$];
  logic [7:0]  ref_bytes [256];
  logic [31:0] slave_mem [64];
  logic [31:0] last_load;
  int          gnt_delay = 0;
  int          rv_delay  = 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int ref_size(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit ref_fault(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a);
    int sz;
    if (!(rd || wr)) return 1'b0;
    sz = ref_size(f3);
    if (sz == 0 || (wr && f3[2])) return 1'b1;
    return (a % 32'(sz)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    int sz;
    sz = ref_size(f3);
    v  = 32'h0;
    for (int k = 0; k < sz; k++)
      v = v | (32'(ref_bytes[8'(a + 32'(k))]) << (8 * k));
    if (!f3[2] && sz < 4 && v[8*sz-1])
      v = v | ~((32'h1 << (8 * sz)) - 32'h1);
    return v;
  endfunction

  task automatic poke_word(input logic [31:0] a, input logic [31:0] w);
    slave_mem[a[7:2]] = w;
    for (int k = 0; k < 4; k++) ref_bytes[8'({a[31:2], 2'b00} + 32'(k))] = 8'(w >> (8 * k));
  endtask

  // Expectations are queued at issue; stall length and data hold are checked by the driver.
  task automatic do_op(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input int gd, input int rvd);
    bit   flt, acc;
    int   sz, n;
    bus_t e;
    flt = ref_fault(rd, wr, f3, a);
    acc = (rd || wr) && !flt;
    sz  = ref_size(f3);
    gnt_delay = gd;
    rv_delay  = rvd;
    memread_MEM = rd; memwrite_MEM = wr; funct3_MEM = f3; addr_MEM = a; store_data_MEM = sd;
    if (acc) begin
      e.we    = wr;
      e.addr  = a & ~32'h3;
      e.be    = wr ? 4'(((1 << sz) - 1) << a[1:0]) : 4'h0;
      e.wdata = (sz == 1) ? {4{sd[7:0]}} : (sz == 2) ? {2{sd[15:0]}} : sd;
      exp_bus.push_back(e);
      if (rd) begin
        last_load = ref_load(f3, a);
        exp_load.push_back(last_load);
      end else begin
        for (int k = 0; k < sz; k++) ref_bytes[8'(a + 32'(k))] = 8'(sd >> (8 * k));
      end
    end
    @(negedge clk);
    chk("fault", 32'(fault_MEM), 32'(flt));
    n = 0;
    while (stall_MEM && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("stall_cycles", 32'(n), acc ? 32'(2 + gd + (rd ? rvd : 0)) : 32'h0);
    if (!(acc && rd)) chk("mem_data_hold", mem_data_MEM, last_load);
    @(posedge clk); #1;
  endtask

  // Memory slave: grants after gnt_delay, returns read data rv_delay cycles after grant,
  // and sprinkles rvalid pulses where they must be ignored.
  initial begin : slave
    logic       s_we;
    logic [5:0] s_idx;
    logic [3:0] s_be;
    logic [31:0] s_wd;
    bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (bus.dmem_req && !reset) begin
        bus.dmem_rvalid = 1'b0;
        repeat (gnt_delay) begin @(posedge clk); #1; end
        bus.dmem_gnt = 1'b1;
        if ($urandom % 100 < 30) begin
          bus.dmem_rvalid = 1'b1;
          bus.dmem_rdata  = $urandom;
        end
        s_we = bus.dmem_we; s_idx = bus.dmem_addr[7:2]; s_be = bus.dmem_be; s_wd = bus.dmem_wdata;
        @(posedge clk); #1;
        bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0;
        if (s_we) begin
          for (int k = 0; k < 4; k++)
            if (s_be[k]) slave_mem[s_idx][8*k +: 8] = s_wd[8*k +: 8];
        end else begin
          repeat (rv_delay - 1) begin @(posedge clk); #1; end
          bus.dmem_rvalid = 1'b1;
          bus.dmem_rdata  = slave_mem[s_idx];
          @(posedge clk); #1;
          bus.dmem_rvalid = 1'b0;
          bus.dmem_rdata  = $urandom;
        end
      end else begin
        bus.dmem_rvalid = ($urandom % 100) < 20;
        bus.dmem_rdata  = $urandom;
      end
    end
  end

  // Monitor: checks each granted request and the load result in the cycle after accepted data.
  initial begin : monitor
    bit   rd_pending = 1'b0;
    bit   chk_next   = 1'b0;
    bus_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        rd_pending = 1'b0; chk_next = 1'b0;
        exp_bus.delete(); exp_load.delete();
        continue;
      end
      if (chk_next) begin
        chk_next = 1'b0;
        if (exp_load.size() == 0) begin
          checks++; errors++;
          $display("FAIL load_data: unexpected load result %h", mem_data_MEM);
        end else begin
          chk("load_data", mem_data_MEM, exp_load.pop_front());
          chk("done_stall", 32'(stall_MEM), 32'h0);
        end
      end
      if (rd_pending && bus.dmem_rvalid) begin
        rd_pending = 1'b0;
        chk_next   = 1'b1;
      end
      if (bus.dmem_req) begin
        if (exp_bus.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req: addr %h we %b expected no request", bus.dmem_addr, bus.dmem_we);
        end else if (bus.dmem_gnt) begin
          e = exp_bus.pop_front();
          chk("bus_we", 32'(bus.dmem_we), 32'(e.we));
          chk("bus_addr", bus.dmem_addr, e.addr);
          chk("bus_be", 32'(bus.dmem_be), 32'(e.be));
          if (e.we) chk("bus_wdata", bus.dmem_wdata, e.wdata);
          else rd_pending = 1'b1;
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : driver
    logic [2:0] legal_f3 [5];
    logic [2:0] f3;
    logic [31:0] a, w;
    bit rd, wr;
    int r;
    legal_f3[0] = 3'd0; legal_f3[1] = 3'd1; legal_f3[2] = 3'd2; legal_f3[3] = 3'd4; legal_f3[4] = 3'd5;
    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      poke_word(32'h100 + 32'(4 * i), w);
    end
    last_load = 32'h0;
    reset = 1'b1;
    memread_MEM = 1'b0; memwrite_MEM = 1'b0; funct3_MEM = 3'd0; addr_MEM = 32'h0; store_data_MEM = 32'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_mem_data", mem_data_MEM, 32'h0);
    chk("reset_req", 32'(bus.dmem_req), 32'h0);
    chk("reset_stall", 32'(stall_MEM), 32'h0);
    @(posedge clk); #1;

    do_op(1'b0, 1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 0, 1);
    do_op(1'b0, 1'b1, 3'd0, 32'h103, 32'h000000A5, 0, 1);
    poke_word(32'h100, 32'h11803344);
    do_op(1'b1, 1'b0, 3'd0, 32'h102, 32'h0, 0, 1);
    do_op(1'b1, 1'b0, 3'd4, 32'h102, 32'h0, 1, 1);
    do_op(1'b1, 1'b0, 3'd5, 32'h102, 32'h0, 0, 2);
    do_op(1'b1, 1'b0, 3'd2, 32'h104, 32'h0, 3, 2);
    do_op(1'b1, 1'b0, 3'd2, 32'h101, 32'h0, 0, 1);
    do_op(1'b1, 1'b0, 3'd1, 32'h103, 32'h0, 0, 1);

    for (int n = 0; n < 200; n++) begin
      r  = int'($urandom % 100);
      rd = (r >= 10 && r < 55);
      wr = (r >= 55);
      f3 = ($urandom % 100 < 15) ? 3'($urandom) : legal_f3[$urandom % 5];
      a  = 32'h100 + ($urandom % 256);
      if ($urandom % 100 < 75) begin
        if (f3[1:0] == 2'd2) a = a & ~32'h3;
        else if (f3[1:0] == 2'd1) a = a & ~32'h1;
      end
      do_op(rd, wr, f3, a, $urandom, int'($urandom % 4), 1 + int'($urandom % 3));
    end
    chk("bus_queue_drained", 32'(exp_bus.size()), 32'h0);
    chk("load_queue_drained", 32'(exp_load.size()), 32'h0);

    // Reset in WAIT_DATA with the response arriving only afterwards.
    gnt_delay = 0; rv_delay = 6;
    memread_MEM = 1'b1; memwrite_MEM = 1'b0; funct3_MEM = 3'd2; addr_MEM = 32'h108;
    begin
      bus_t e;
      e.we = 1'b0; e.addr = 32'h108; e.be = 4'h0; e.wdata = 32'h0;
      exp_bus.push_back(e);
    end
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_req", 32'(bus.dmem_req), 32'h0);
    chk("rst_mid_mem_data", mem_data_MEM, 32'h0);
    @(negedge clk);
    #2 reset = 1'b0; memread_MEM = 1'b0;
    last_load = 32'h0;
    repeat (10) @(negedge clk);
    chk("rst_late_rvalid_data", mem_data_MEM, 32'h0);
    chk("rst_idle_stall", 32'(stall_MEM), 32'h0);
    chk("rst_idle_req", 32'(bus.dmem_req), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
